// File: rtl/udp_panel_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_panel_pkg
// Description : Shared constants, header field positions and FSM state type
//               for the UDP panel router.
// Revision    : 1.0 - initial release
// ============================================================================
package udp_panel_pkg;

    // Header marker and broadcast panel id
    localparam logic [7:0] MAGIC    = 8'hA5;
    localparam logic [7:0] BCAST_ID = 8'hFF;

    // Header beat field positions (bank field grows downward from HDR_BANK_HI)
    localparam int HDR_MAGIC_HI = 31;
    localparam int HDR_MAGIC_LO = 24;
    localparam int HDR_ID_HI    = 23;
    localparam int HDR_ID_LO    = 16;
    localparam int HDR_BANK_HI  = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/udp_panel_router_if.sv
`default_nettype none
// ============================================================================
// Module      : udp_panel_router_if
// Description : UDP payload stream from the Ethernet core into the router.
//               master = Ethernet core side, slave = router side.
// Revision    : 1.0 - initial release
// ============================================================================
interface udp_panel_router_if;
    logic        valid;
    logic        last;
    logic        ready;
    logic [15:0] dst_port;
    logic [31:0] data;
    logic [3:0]  error;

    modport master (output valid, last, dst_port, data, error, input ready);
    modport slave  (input valid, last, dst_port, data, error, output ready);
endinterface
`default_nettype wire

// File: rtl/udp_panel_router_panel_en_decode.sv
`default_nettype none
// ============================================================================
// Module      : panel_en_decode
// Description : Converts a panel id into a one-hot enable vector, or all ones
//               for the broadcast id.
// Revision    : 1.0 - initial release
// ============================================================================
module panel_en_decode
    import udp_panel_pkg::*;
#(
    parameter int NUM_PANELS = 9
) (
    input  wire logic [7:0]            i_id,
    output logic      [NUM_PANELS-1:0] o_en
);

    logic w_bcast;

    assign w_bcast = (i_id == BCAST_ID);

    for (genvar gi = 0; gi < NUM_PANELS; gi++) begin : g_en
        assign o_en[gi] = w_bcast | (i_id == 8'(gi));
    end

endmodule
`default_nettype wire

// File: rtl/udp_panel_router.sv
`default_nettype none
// ============================================================================
// Module      : udp_panel_router
// Description : Parses UDP payload beats (header, start address, pixels) and
//               issues single-cycle pixel writes to one panel or to all panels.
//               Optional macro PKT_STATS_EN adds saturating ok/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_panel_router
    import udp_panel_pkg::*;
#(
    parameter int NUM_PANELS = 9,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 24,
    parameter int WR_W       = 3,
    parameter int MAX_ADDR   = 4095,
    parameter int UDP_PORT   = 26177
) (
    input  wire logic                  clock,
    input  wire logic                  resetn,
    udp_panel_router_if.slave          udp_source,
    output logic      [NUM_PANELS-1:0] ctrl_en,
    output logic      [WR_W-1:0]       ctrl_wr,
    output logic      [ADDR_W-1:0]     ctrl_addr,
    output logic      [DATA_W-1:0]     ctrl_wdat,
    output logic                       led_reg
`ifdef PKT_STATS_EN
    ,
    output logic      [15:0]           pkt_ok_count,
    output logic      [15:0]           pkt_drop_count
`endif
);

    localparam logic [ADDR_W-1:0] c_max_addr = ADDR_W'(MAX_ADDR);
    localparam logic [15:0]       c_port     = 16'(UDP_PORT);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_ready;
    logic [7:0]              r_id;
    logic [WR_W-1:0]         r_bank;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_trunc;
    logic [NUM_PANELS-1:0]   w_en_vec;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_err;
    logic [7:0]              w_id;
    logic                    w_hdr_ok;
    logic                    w_over;
    logic                    w_latch_hdr;
    logic                    w_latch_addr;
    logic                    w_step;
    logic                    w_write;
    logic                    w_ok;
    logic                    w_drop;

    assign udp_source.ready = r_ready;
    assign w_accept = udp_source.valid & r_ready;
    assign w_last   = udp_source.last;
    assign w_err    = |udp_source.error;
    assign w_id     = udp_source.data[HDR_ID_HI:HDR_ID_LO];
    assign w_hdr_ok = (udp_source.dst_port == c_port)
                    && (udp_source.data[HDR_MAGIC_HI:HDR_MAGIC_LO] == MAGIC)
                    && !w_err
                    && (({24'd0, w_id} < 32'(NUM_PANELS)) || (w_id == BCAST_ID));
    // Once past MAX_ADDR (or after writing it) the rest of the packet is dropped
    assign w_over   = r_trunc | (r_addr > c_max_addr);

    panel_en_decode #(
        .NUM_PANELS (NUM_PANELS)
    ) u_en_decode (
        .i_id (r_id),
        .o_en (w_en_vec)
    );

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept && !w_last) w_next = w_hdr_ok ? ADDR : DROP;
            ADDR: if (w_accept)            w_next = w_last ? IDLE : (w_err ? DROP : DATA);
            DATA: if (w_accept)            w_next = w_last ? IDLE : (w_err ? DROP : DATA);
            DROP: if (w_accept && w_last)  w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    // Per-beat actions; every drop is counted once at the beat that decides it
    always_comb begin
        w_latch_hdr  = 1'b0;
        w_latch_addr = 1'b0;
        w_step       = 1'b0;
        w_write      = 1'b0;
        w_ok         = 1'b0;
        w_drop       = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    w_latch_hdr = w_hdr_ok && !w_last;
                    w_drop      = !(w_hdr_ok && !w_last);
                end
                ADDR: begin
                    w_latch_addr = 1'b1;
                    w_drop       = w_last | w_err;
                end
                DATA: begin
                    if (w_err) begin
                        w_drop = 1'b1;
                    end else begin
                        w_step  = 1'b1;
                        w_write = !w_over;
                        w_ok    = w_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and registered write bus
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ready   <= 1'b0;
            r_id      <= '0;
            r_bank    <= '0;
            r_addr    <= '0;
            r_trunc   <= 1'b0;
            ctrl_en   <= '0;
            ctrl_wr   <= '0;
            ctrl_addr <= '0;
            ctrl_wdat <= '0;
            led_reg   <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            if (w_latch_hdr) begin
                r_id   <= w_id;
                r_bank <= udp_source.data[HDR_BANK_HI -: WR_W];
            end
            if (w_latch_addr) begin
                r_addr  <= udp_source.data[ADDR_W-1:0];
                r_trunc <= 1'b0;
            end
            if (w_step) begin
                r_addr  <= r_addr + 1'b1;
                r_trunc <= w_over | (r_addr == c_max_addr);
            end
            ctrl_en <= w_write ? w_en_vec : '0;
            if (w_write) begin
                ctrl_wr   <= r_bank;
                ctrl_addr <= r_addr;
                ctrl_wdat <= udp_source.data[DATA_W-1:0];
            end
            if (w_ok) led_reg <= ~led_reg;
        end
    end

`ifdef PKT_STATS_EN
    logic [15:0] r_ok_cnt;
    logic [15:0] r_drop_cnt;

    // Saturating packet statistics
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ok_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_ok && (r_ok_cnt != 16'hFFFF))     r_ok_cnt   <= r_ok_cnt + 16'd1;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign pkt_ok_count   = r_ok_cnt;
    assign pkt_drop_count = r_drop_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_panel_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_panel_router
// Description : Directed self-checking bench for udp_panel_router with a
//               write scoreboard. Honours PKT_STATS_EN for the counter ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_panel_router;

    localparam logic [15:0] c_port = 16'd26177;

    typedef struct {
        logic [8:0]  en;
        logic [2:0]  wr;
        logic [15:0] addr;
        logic [23:0] wdat;
    } wr_t;

    logic        clock;
    logic        resetn;
    logic [8:0]  ctrl_en;
    logic [2:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic        led_reg;
`ifdef PKT_STATS_EN
    logic [15:0] pkt_ok_count;
    logic [15:0] pkt_drop_count;
`endif

    int  n_cmp = 0;
    int  n_err = 0;
    wr_t sb[$];
    logic        exp_led;
    int          exp_ok;
    int          exp_drop;

    udp_panel_router_if u_if ();

    udp_panel_router dut (
        .clock          (clock),
        .resetn         (resetn),
        .udp_source     (u_if),
        .ctrl_en        (ctrl_en),
        .ctrl_wr        (ctrl_wr),
        .ctrl_addr      (ctrl_addr),
        .ctrl_wdat      (ctrl_wdat),
        .led_reg        (led_reg)
`ifdef PKT_STATS_EN
        ,
        .pkt_ok_count   (pkt_ok_count),
        .pkt_drop_count (pkt_drop_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] en, input logic [2:0] wr,
                        input logic [15:0] addr, input logic [23:0] wdat);
        wr_t w;
        w.en = en; w.wr = wr; w.addr = addr; w.wdat = wdat;
        sb.push_back(w);
    endtask

    // One beat; waits (bounded) for ready, returns 1 time unit after acceptance
    task automatic beat(input logic [31:0] d, input logic lst,
                        input logic [3:0] e, input logic [15:0] port);
        int n;
        n = 0;
        u_if.valid = 1'b1; u_if.data = d; u_if.last = lst;
        u_if.error = e;    u_if.dst_port = port;
        while (!u_if.ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) chk("ready_timeout", {31'd0, u_if.ready}, 32'd1);
        @(posedge clock); #1;
        u_if.valid = 1'b0; u_if.last = 1'b0; u_if.error = 4'd0;
    endtask

    task automatic check_pkt_end(input string tag);
        chk({tag, "_led"}, {31'd0, led_reg}, {31'd0, exp_led});
`ifdef PKT_STATS_EN
        chk({tag, "_ok"},   {16'd0, pkt_ok_count},   32'(exp_ok));
        chk({tag, "_drop"}, {16'd0, pkt_drop_count}, 32'(exp_drop));
`endif
    endtask

    // Write monitor: every enabled cycle must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clock);
            if (ctrl_en !== 9'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_en", {23'd0, ctrl_en}, 32'd0);
                end else begin
                    wr_t w;
                    w = sb.pop_front();
                    chk("wr_en",   {23'd0, ctrl_en},   {23'd0, w.en});
                    chk("wr_bank", {29'd0, ctrl_wr},   {29'd0, w.wr});
                    chk("wr_addr", {16'd0, ctrl_addr}, {16'd0, w.addr});
                    chk("wr_data", {8'd0,  ctrl_wdat}, {8'd0,  w.wdat});
                end
            end
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        u_if.valid = 1'b0; u_if.last = 1'b0; u_if.error = 4'd0;
        u_if.data = 32'd0; u_if.dst_port = 16'd0;
        exp_led = 1'b0; exp_ok = 0; exp_drop = 0;

        // Reset state
        #12;
        chk("rst_en",    {23'd0, ctrl_en},   32'd0);
        chk("rst_wr",    {29'd0, ctrl_wr},   32'd0);
        chk("rst_addr",  {16'd0, ctrl_addr}, 32'd0);
        chk("rst_wdat",  {8'd0,  ctrl_wdat}, 32'd0);
        chk("rst_led",   {31'd0, led_reg},   32'd0);
        chk("rst_ready", {31'd0, u_if.ready}, 32'd0);
        @(negedge clock); resetn = 1'b1;
        @(posedge clock); #1;
        chk("ready_up", {31'd0, u_if.ready}, 32'd1);

        // Unicast to panel 3, bank 1, two pixels
        push(9'h008, 3'd1, 16'h0010, 24'h112233);
        push(9'h008, 3'd1, 16'h0011, 24'h445566);
        beat(32'hA503_2000, 1'b0, 4'd0, c_port);
        beat(32'h0000_0010, 1'b0, 4'd0, c_port);
        beat(32'h0011_2233, 1'b0, 4'd0, c_port);
        beat(32'h0044_5566, 1'b1, 4'd0, c_port);
        exp_led = ~exp_led; exp_ok++;
        check_pkt_end("unicast");
        repeat (2) @(posedge clock);
        #1 chk("en_idle", {23'd0, ctrl_en}, 32'd0);

        // Broadcast, bank 7, one pixel
        push(9'h1FF, 3'd7, 16'h0005, 24'hFFFFFF);
        beat(32'hA5FF_E000, 1'b0, 4'd0, c_port);
        beat(32'h0000_0005, 1'b0, 4'd0, c_port);
        beat(32'h00FF_FFFF, 1'b1, 4'd0, c_port);
        exp_led = ~exp_led; exp_ok++;
        check_pkt_end("bcast");

        // Rejections: bad magic, id out of range, wrong port
        beat(32'h5A00_0000, 1'b0, 4'd0, c_port);
        beat(32'h0000_0001, 1'b0, 4'd0, c_port);
        beat(32'h0012_3456, 1'b1, 4'd0, c_port);
        exp_drop++;
        beat(32'hA509_0000, 1'b0, 4'd0, c_port);
        beat(32'h0000_0001, 1'b0, 4'd0, c_port);
        beat(32'h0012_3456, 1'b1, 4'd0, c_port);
        exp_drop++;
        beat(32'hA500_0000, 1'b0, 4'd0, 16'd80);
        beat(32'h0000_0001, 1'b0, 4'd0, 16'd80);
        beat(32'h0012_3456, 1'b1, 4'd0, 16'd80);
        exp_drop++;
        check_pkt_end("reject");

        // Truncation at MAX_ADDR
        push(9'h001, 3'd0, 16'd4094, 24'h000001);
        push(9'h001, 3'd0, 16'd4095, 24'h000002);
        beat(32'hA500_0000, 1'b0, 4'd0, c_port);
        beat(32'h0000_0FFE, 1'b0, 4'd0, c_port);
        beat(32'h0000_0001, 1'b0, 4'd0, c_port);
        beat(32'h0000_0002, 1'b0, 4'd0, c_port);
        beat(32'h0000_0003, 1'b0, 4'd0, c_port);
        beat(32'h0000_0004, 1'b1, 4'd0, c_port);
        exp_led = ~exp_led; exp_ok++;
        check_pkt_end("trunc");

        // Error on the third of five pixels
        push(9'h004, 3'd2, 16'h0100, 24'hA00001);
        push(9'h004, 3'd2, 16'h0101, 24'hA00002);
        beat(32'hA502_4000, 1'b0, 4'd0, c_port);
        beat(32'h0000_0100, 1'b0, 4'd0, c_port);
        beat(32'h00A0_0001, 1'b0, 4'd0, c_port);
        beat(32'h00A0_0002, 1'b0, 4'd0, c_port);
        beat(32'h00A0_0003, 1'b0, 4'd1, c_port);
        beat(32'h00A0_0004, 1'b0, 4'd0, c_port);
        beat(32'h00A0_0005, 1'b1, 4'd0, c_port);
        exp_drop++;
        check_pkt_end("err");

        // Reset pulse during DATA
        push(9'h010, 3'd3, 16'h0200, 24'h123456);
        beat(32'hA504_6000, 1'b0, 4'd0, c_port);
        beat(32'h0000_0200, 1'b0, 4'd0, c_port);
        beat(32'h0012_3456, 1'b0, 4'd0, c_port);
        @(negedge clock); #1;
        resetn = 1'b0;
        #1;
        chk("arst_en",    {23'd0, ctrl_en},    32'd0);
        chk("arst_addr",  {16'd0, ctrl_addr},  32'd0);
        chk("arst_wdat",  {8'd0,  ctrl_wdat},  32'd0);
        chk("arst_wr",    {29'd0, ctrl_wr},    32'd0);
        chk("arst_led",   {31'd0, led_reg},    32'd0);
        chk("arst_ready", {31'd0, u_if.ready}, 32'd0);
        #2 resetn = 1'b1;
        exp_led = 1'b0; exp_ok = 0; exp_drop = 0;
        beat(32'h00AB_CDEF, 1'b0, 4'd0, c_port);
        beat(32'h0000_0001, 1'b1, 4'd0, c_port);
        exp_drop++;
        check_pkt_end("leftover");

        push(9'h002, 3'd2, 16'h0020, 24'h0A0B0C);
        beat(32'hA501_4000, 1'b0, 4'd0, c_port);
        beat(32'h0000_0020, 1'b0, 4'd0, c_port);
        beat(32'h000A_0B0C, 1'b1, 4'd0, c_port);
        exp_led = ~exp_led; exp_ok++;
        check_pkt_end("post_rst");

        repeat (3) @(posedge clock);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_en",   {23'd0, ctrl_en}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
